sdf_stage_ctrl: RTL and testbench

Sequencer for one radix-2 single-path delay-feedback (R2SDF, DIF) FFT stage built around a DELAY-deep 32-bit delay line that shifts every clock.
- Tracks the sample index within a frame.
- Drives the butterfly/bypass mux select, the zero-feed mux, and the twiddle ROM address/enable.
- Generates output valid and frame markers aligned to the stage output.
- Drains the delay line after the last frame and flags framing errors.

---
 rtl/sdf_stage_ctrl_if.sv | 42 ++++
 rtl/sdf_stage_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sdf_stage_ctrl_if.sv
// Handshake and control bundle for one R2SDF FFT stage sequencer.
//   master : sample source / datapath side (drives in_valid, in_sof)
//   slave  : sdf_stage_ctrl (drives ready, mux selects, twiddle
//            address/enable, output markers and error pulses)
// Signals:
//   in_valid, in_sof      - input sample present / first sample of frame
//   in_ready              - stage accepts samples (low only while draining)
//   bf_sel, feed_zero     - butterfly/bypass select, delay-line zero feed
//   tw_en, tw_addr        - twiddle multiply enable and ROM address
//   out_valid, out_sof,
//   out_eof               - output qualifier and frame/drain markers
//   busy                  - sequencer not idle
//   err_gap, err_sof      - one-cycle framing error pulses
interface sdf_stage_ctrl_if #(
  parameter int TW_AW = 4
);
  logic             in_valid;
  logic             in_sof;
  logic             in_ready;
  logic             bf_sel;
  logic             feed_zero;
  logic             tw_en;
  logic [TW_AW-1:0] tw_addr;
  logic             out_valid;
  logic             out_sof;
  logic             out_eof;
  logic             busy;
  logic             err_gap;
  logic             err_sof;

  modport master (
    output in_valid, in_sof,
    input  in_ready, bf_sel, feed_zero, tw_en, tw_addr,
           out_valid, out_sof, out_eof, busy, err_gap, err_sof
  );

  modport slave (
    input  in_valid, in_sof,
    output in_ready, bf_sel, feed_zero, tw_en, tw_addr,
           out_valid, out_sof, out_eof, busy, err_gap, err_sof
  );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback (DIF) FFT stage
// built around a DELAY-deep delay line that shifts every clock.
// Tracks the sample index within a frame, drives the butterfly/bypass and
// zero-feed muxes plus the twiddle ROM, marks output valid/sof/eof, drains
// the delay line after the last frame and flags framing errors.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - sdf_stage_ctrl_if slave modport (handshake and control outputs)
module sdf_stage_ctrl #(
  parameter int DELAY   = 4,
  parameter int N       = 16,
  parameter int TW_AW   = 4,
  parameter int TW_STEP = 2
) (
  input  logic           clk,
  input  logic           rst,
  sdf_stage_ctrl_if.slave bus
);

  localparam int LOG2D = $clog2(DELAY);
  localparam int LOG2N = $clog2(N);
  localparam int PW    = TW_AW + LOG2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LOG2D-1:0] drn_q, drn_d;
  logic             have_prev_q, have_prev_d;
  logic             err_gap_q, err_gap_d;
  logic             err_sof_q, err_sof_d;

  logic             ph;
  logic [LOG2D-1:0] k;
  logic             accept;
  logic [LOG2D-1:0] tw_idx;

  assign ph = cnt_q[LOG2D];
  assign k  = cnt_q[LOG2D-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      drn_q       <= '0;
      have_prev_q <= 1'b0;
      err_gap_q   <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      have_prev_q <= have_prev_d;
      err_gap_q   <= err_gap_d;
      err_sof_q   <= err_sof_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    drn_d         = drn_q;
    have_prev_d   = have_prev_q;
    err_gap_d     = 1'b0;
    err_sof_d     = 1'b0;
    accept        = 1'b0;
    tw_idx        = '0;

    bus.in_ready  = 1'b1;
    bus.bf_sel    = 1'b0;
    bus.feed_zero = 1'b1;
    bus.tw_en     = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sof   = 1'b0;
    bus.out_eof   = 1'b0;
    bus.busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_sof) begin
            accept  = 1'b1;
            state_d = RUN;
          end else begin
            err_sof_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (cnt_q != '0) begin
          if (bus.in_valid) begin
            accept    = 1'b1;
            err_sof_d = bus.in_sof;
          end else begin
            err_gap_d   = 1'b1;
            state_d     = IDLE;
            cnt_d       = '0;
            have_prev_d = 1'b0;
          end
        end else if (bus.in_valid && bus.in_sof) begin
          accept = 1'b1;
        end else begin
          // Frame boundary without a follow-on frame: this cycle already
          // presents drain slot 0 so the output stream stays contiguous;
          // the DRAIN state then covers slots 1..DELAY-1.
          err_sof_d     = bus.in_valid;
          state_d       = DRAIN;
          drn_d         = LOG2D'(1);
          bus.in_ready  = 1'b0;
          bus.tw_en     = 1'b1;
          bus.out_valid = 1'b1;
        end
      end

      DRAIN: begin
        bus.in_ready  = 1'b0;
        bus.tw_en     = 1'b1;
        bus.out_valid = 1'b1;
        tw_idx        = drn_q;
        if (drn_q == LOG2D'(DELAY - 1)) begin
          bus.out_eof = 1'b1;
          state_d     = IDLE;
          drn_d       = '0;
          have_prev_d = 1'b0;
        end else begin
          drn_d = drn_q + LOG2D'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      cnt_d         = cnt_q + LOG2N'(1);
      bus.feed_zero = 1'b0;
      bus.bf_sel    = ph;
      bus.tw_en     = !ph && have_prev_q;
      tw_idx        = (!ph && have_prev_q) ? k : '0;
      bus.out_valid = ph || have_prev_q;
      bus.out_sof   = (cnt_q == LOG2N'(DELAY));
      if (ph) begin
        have_prev_d = 1'b1;
      end
    end

    bus.tw_addr = TW_AW'(PW'(tw_idx) * PW'(TW_STEP));
  end

  assign bus.err_gap = err_gap_q;
  assign bus.err_sof = err_sof_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Directed testbench for sdf_stage_ctrl (DELAY=4, N=16, TW_AW=4, TW_STEP=2).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_sdf_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sdf_stage_ctrl_if #(.TW_AW(4)) bus ();

  sdf_stage_ctrl #(
    .DELAY  (4),
    .N      (16),
    .TW_AW  (4),
    .TW_STEP(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       in_ready;
    logic       bf_sel;
    logic       feed_zero;
    logic       tw_en;
    logic [3:0] tw_addr;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       busy;
    logic       err_gap;
    logic       err_sof;
  } ob_t;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  function automatic ob_t mk(bit rdy, bit bf, bit fz, bit te, logic [3:0] a,
                             bit ov, bit os, bit oe, bit bs, bit eg, bit es);
    ob_t r;
    r = '{in_ready: rdy, bf_sel: bf, feed_zero: fz, tw_en: te, tw_addr: a,
          out_valid: ov, out_sof: os, out_eof: oe, busy: bs,
          err_gap: eg, err_sof: es};
    return r;
  endfunction

  function automatic ob_t observe();
    ob_t r;
    r = '{in_ready: bus.in_ready, bf_sel: bus.bf_sel, feed_zero: bus.feed_zero,
          tw_en: bus.tw_en, tw_addr: bus.tw_addr, out_valid: bus.out_valid,
          out_sof: bus.out_sof, out_eof: bus.out_eof, busy: bus.busy,
          err_gap: bus.err_gap, err_sof: bus.err_sof};
    return r;
  endfunction

  task automatic drive(input logic v, input logic s);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    #1;
  endtask

  task automatic check(input string tag, input ob_t exp);
    ob_t o;
    o = observe();
    vectors++;
    assert (o === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, o, exp);
    end
  endtask

  // One frame of n contiguous samples; first=1 means it starts from IDLE
  // (no previous frame in the delay line). bad_sof marks a sample index that
  // carries a spurious in_sof (-1 for none).
  task automatic run_frame(input string tag, input bit first, input int n,
                           input int bad_sof);
    logic [15:0] bf_map;
    logic [15:0] te_map;
    logic [15:0] ov_map;
    logic [3:0]  addr_tab [4];
    bit          te;
    bf_map   = 16'hF0F0;
    te_map   = first ? 16'h0F00 : 16'h0F0F;
    ov_map   = first ? 16'hFFF0 : 16'hFFFF;
    addr_tab = '{4'd0, 4'd2, 4'd4, 4'd6};
    for (int c = 0; c < n; c++) begin
      drive(1'b1, (c == 0) || (c == bad_sof));
      te = te_map[c];
      check($sformatf("%s_c%0d", tag, c),
            mk(1'b1, bf_map[c], 1'b0, te, te ? addr_tab[c % 4] : 4'd0,
               ov_map[c], c == 4, 1'b0, !(first && c == 0), 1'b0,
               (bad_sof >= 0) && (c == bad_sof + 1)));
    end
  endtask

  // Four drain slots; hold=1 keeps in_valid high from slot 1 on.
  task automatic run_drain(input string tag, input bit hold);
    logic [3:0] addr_tab [4];
    addr_tab = '{4'd0, 4'd2, 4'd4, 4'd6};
    for (int d = 0; d < 4; d++) begin
      drive(hold && d != 0, 1'b0);
      check($sformatf("%s_d%0d", tag, d),
            mk(1'b0, 1'b0, 1'b1, 1'b1, addr_tab[d], 1'b1, 1'b0, d == 3,
               1'b1, 1'b0, 1'b0));
    end
  endtask

  ob_t idle_exp;

  initial begin
    idle_exp     = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;

    // Reset state
    rst = 1'b0;
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    check("reset", idle_exp);
    rst = 1'b1;

    // Single frame, drain, back to IDLE
    run_frame("single", 1'b1, 16, -1);
    run_drain("single_drain", 1'b0);
    drive(1'b0, 1'b0);
    check("single_idle", idle_exp);

    // Back-to-back frames, one drain at the end
    run_frame("b2b_a", 1'b1, 16, -1);
    run_frame("b2b_b", 1'b0, 16, -1);
    run_drain("b2b_drain", 1'b0);
    drive(1'b0, 1'b0);
    check("b2b_idle", idle_exp);

    // Gap at cnt=6
    run_frame("gap", 1'b1, 6, -1);
    drive(1'b0, 1'b0);
    check("gap_c6", mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                       1'b1, 1'b0, 1'b0));
    drive(1'b0, 1'b0);
    check("gap_pulse", mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b1, 1'b0));
    drive(1'b0, 1'b0);
    check("gap_after", idle_exp);

    // in_valid without sof in IDLE
    drive(1'b1, 1'b0);
    check("nosof_idle", idle_exp);
    drive(1'b0, 1'b0);
    check("nosof_pulse", mk(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 1'b1));
    drive(1'b0, 1'b0);
    check("nosof_after", idle_exp);

    // Spurious sof at cnt=9; count continues
    run_frame("sof9", 1'b1, 16, 9);
    run_drain("sof9_drain", 1'b0);
    drive(1'b0, 1'b0);
    check("sof9_idle", idle_exp);

    // Reset at drain slot 2, then a fresh frame
    run_frame("rstd", 1'b1, 16, -1);
    drive(1'b0, 1'b0);
    check("rstd_d0", mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0,
                        1'b1, 1'b0, 1'b0));
    drive(1'b0, 1'b0);
    check("rstd_d1", mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0,
                        1'b1, 1'b0, 1'b0));
    drive(1'b0, 1'b0);
    check("rstd_d2", mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0,
                        1'b1, 1'b0, 1'b0));
    rst = 1'b0;
    drive(1'b0, 1'b0);
    rst = 1'b1;
    check("rstd_after", idle_exp);
    run_frame("rstd_new", 1'b1, 16, -1);
    run_drain("rstd_new_drain", 1'b0);
    drive(1'b0, 1'b0);
    check("rstd_new_idle", idle_exp);

    // in_valid held high through the drain
    run_frame("hold", 1'b1, 16, -1);
    run_drain("hold_drain", 1'b1);
    drive(1'b0, 1'b0);
    check("hold_idle", idle_exp);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
